// File: rtl/fb_arb_pkg.sv
// Shared widths, write-entry payload and arbiter state encoding for the frame buffer port arbiter.
package fb_arb_pkg;

  localparam int unsigned FB_ADDR_W = 17;
  localparam int unsigned FB_DATA_W = 12;
  localparam int unsigned FB_PIXELS = 76800;
  localparam int unsigned DROP_W    = 16;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } fb_wr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAIN = 2'd2
  } fb_arb_state_t;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Requester and BRAM side signals of the frame buffer arbiter.
// master: the surrounding system (display, camera, control, BRAM); slave: the arbiter.
interface fb_port_arbiter_if;
  import fb_arb_pkg::*;

  logic                 rd_oe;
  logic [FB_ADDR_W-1:0] rd_addr;
  logic [FB_DATA_W-1:0] rd_data;
  logic                 cam_we;
  logic [FB_ADDR_W-1:0] cam_addr;
  logic [FB_DATA_W-1:0] cam_wdata;
  logic                 cam_ready;
  logic                 clr_start;
  logic                 clr_busy;
  logic                 ovf_clr;
  logic                 ovf_flag;
  logic [DROP_W-1:0]    drop_cnt;
  logic                 mem_en;
  logic                 mem_we;
  logic [FB_ADDR_W-1:0] mem_addr;
  logic [FB_DATA_W-1:0] mem_wdata;
  logic [FB_DATA_W-1:0] mem_rdata;

  modport master (
    output rd_oe, rd_addr, cam_we, cam_addr, cam_wdata, clr_start, ovf_clr, mem_rdata,
    input  rd_data, cam_ready, clr_busy, ovf_flag, drop_cnt, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rd_oe, rd_addr, cam_we, cam_addr, cam_wdata, clr_start, ovf_clr, mem_rdata,
    output rd_data, cam_ready, clr_busy, ovf_flag, drop_cnt, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO holding camera writes until a free BRAM cycle.
module fb_wr_fifo
  import fb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  fb_wr_t           din,
  output fb_wr_t           head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fb_wr_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  // Entry storage; no reset needed, validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  // Pointers and occupancy; the caller never pops empty or pushes full without a pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame buffer arbiter: display reads win, then the clear engine, then queued camera writes.
module fb_port_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned          FIFO_DEPTH  = 16,
  parameter logic [FB_DATA_W-1:0] CLEAR_COLOR = 12'h000,
  parameter int unsigned          FB_PIXELS   = fb_arb_pkg::FB_PIXELS
) (
  input logic             clk,
  input logic             reset_n,
  fb_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  fb_arb_state_t        state_q, state_nxt;
  logic [FB_ADDR_W-1:0] clr_ptr_q, clr_ptr_nxt;
  logic                 clr_busy_q;
  logic                 cam_ready_q;
  logic                 ovf_flag_q;
  logic [DROP_W-1:0]    drop_cnt_q;

  fb_wr_t               fifo_head;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [CNT_W-1:0]     count_nxt;

  // Camera accepts whenever there is room or a slot frees up this cycle.
  assign push      = bus.cam_we && (!fifo_full || pop);
  assign drop      = bus.cam_we && !push;
  assign count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);

  fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     ({bus.cam_addr, bus.cam_wdata}),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // State, clear pointer and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      clr_ptr_q   <= '0;
      clr_busy_q  <= 1'b0;
      cam_ready_q <= 1'b1;
      ovf_flag_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_nxt;
      clr_ptr_q   <= clr_ptr_nxt;
      clr_busy_q  <= (state_nxt == CLEAR);
      cam_ready_q <= (count_nxt < CNT_W'(FIFO_DEPTH));
      if (bus.ovf_clr) begin
        ovf_flag_q <= 1'b0;
        drop_cnt_q <= '0;
      end else if (drop) begin
        ovf_flag_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_W'(1);
      end
    end
  end

  // Per-cycle grant mux and next-state; reads are never stalled.
  always_comb begin
    state_nxt     = state_q;
    clr_ptr_nxt   = clr_ptr_q;
    pop           = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = bus.rd_addr;
    bus.mem_wdata = CLEAR_COLOR;

    if (bus.rd_oe) begin
      bus.mem_en = 1'b1;
    end else if (state_q == CLEAR) begin
      bus.mem_en   = 1'b1;
      bus.mem_we   = 1'b1;
      bus.mem_addr = clr_ptr_q;
      clr_ptr_nxt  = clr_ptr_q + FB_ADDR_W'(1);
      if (clr_ptr_q == FB_ADDR_W'(FB_PIXELS - 1)) state_nxt = DRAIN;
    end else if (!fifo_empty) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = fifo_head.addr;
      bus.mem_wdata = fifo_head.data;
      pop           = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.clr_start) begin
          state_nxt   = CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      DRAIN: begin
        if (fifo_empty) state_nxt = IDLE;
      end
      default: ;
    endcase

    // Keep the BRAM quiet while reset is held.
    if (!reset_n) begin
      bus.mem_en = 1'b0;
      bus.mem_we = 1'b0;
    end
  end

  assign bus.rd_data   = bus.mem_rdata;
  assign bus.cam_ready = cam_ready_q;
  assign bus.clr_busy  = clr_busy_q;
  assign bus.ovf_flag  = ovf_flag_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_fb_port_arbiter;
  import fb_arb_pkg::*;

  localparam int unsigned          DEPTH = 16;
  localparam int unsigned          NPIX  = 2048;
  localparam logic [FB_DATA_W-1:0] CCOL  = 12'h3C5;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  fb_port_arbiter_if bus ();

  fb_port_arbiter #(
    .FIFO_DEPTH  (DEPTH),
    .CLEAR_COLOR (CCOL),
    .FB_PIXELS   (NPIX)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural single-port BRAM, one-cycle read latency.
  logic [FB_DATA_W-1:0] bram [NPIX];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) bram[11'(bus.mem_addr)] <= bus.mem_wdata;
      else            bus.mem_rdata <= bram[11'(bus.mem_addr)];
    end
  end

  // Reference model: pending camera writes, expected memory image, clear progress, drop accounting.
  fb_wr_t               q[$];
  logic [FB_DATA_W-1:0] exp_fb [NPIX];
  bit                   m_clearing, m_draining, m_ovf;
  int                   m_clr, m_drops;
  int                   last_cam [int];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_clearing = 0;
    m_draining = 0;
    m_clr      = 0;
    m_ovf      = 0;
    m_drops    = 0;
  endtask

  // One clock cycle: drive, check grant mid-cycle, advance model at the edge, check status after it.
  task automatic step(input bit rd, input int ra, input bit we, input int wa,
                      input logic [FB_DATA_W-1:0] wd, input bit st, input bit oc);
    logic [30:0]          exp_bus, obs_bus;
    logic [FB_DATA_W-1:0] exp_rd;
    bit                   pop, cw, push, drop, was_idle;
    bus.rd_oe     = rd;
    bus.rd_addr   = 17'(ra);
    bus.cam_we    = we;
    bus.cam_addr  = 17'(wa);
    bus.cam_wdata = wd;
    bus.clr_start = st;
    bus.ovf_clr   = oc;
    @(negedge clk);
    pop    = 0;
    cw     = 0;
    exp_rd = '0;
    if (rd) begin
      exp_bus = {1'b1, 1'b0, 17'(ra), 12'h000};
      exp_rd  = exp_fb[ra];
    end else if (m_clearing) begin
      cw      = 1;
      exp_bus = {2'b11, 17'(m_clr), CCOL};
    end else if (q.size() > 0) begin
      pop     = 1;
      exp_bus = {2'b11, q[0].addr, q[0].data};
    end else begin
      exp_bus = '0;
    end
    obs_bus = {bus.mem_en, bus.mem_we, bus.mem_en ? bus.mem_addr : 17'h0,
               bus.mem_we ? bus.mem_wdata : 12'h000};
    chk("grant", 64'(obs_bus), 64'(exp_bus));
    @(posedge clk);
    was_idle = !m_clearing && !m_draining;
    if (m_draining && q.size() == 0) m_draining = 0;
    if (cw) begin
      exp_fb[m_clr] = CCOL;
      if (m_clr == NPIX - 1) begin
        m_clearing = 0;
        m_draining = 1;
      end
      m_clr++;
    end
    if (was_idle && st) begin
      m_clearing = 1;
      m_clr      = 0;
    end
    if (pop) exp_fb[q[0].addr] = q[0].data;
    push = we && (q.size() < DEPTH || pop);
    drop = we && !push;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back('{addr: 17'(wa), data: wd});
    if (oc) begin
      m_ovf   = 0;
      m_drops = 0;
    end else if (drop) begin
      m_ovf = 1;
      if (m_drops < 65535) m_drops++;
    end
    #1;
    chk("status", 64'({bus.cam_ready, bus.clr_busy, bus.ovf_flag, bus.drop_cnt}),
        64'({q.size() < DEPTH, m_clearing, m_ovf, 16'(m_drops)}));
    if (rd) chk("rd_data", 64'(bus.rd_data), 64'(exp_rd));
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    int busy_cnt, good, nwr;
    bit rd;
    bus.rd_oe = 1'b1; bus.rd_addr = 17'd5; bus.cam_we = 1'b0; bus.cam_addr = '0;
    bus.cam_wdata = '0; bus.clr_start = 1'b0; bus.ovf_clr = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #2;
    chk("rst_mem_quiet", 64'({bus.mem_en, bus.mem_we}), 64'(2'b00));
    repeat (3) @(negedge clk);
    chk("rst_status", 64'({bus.cam_ready, bus.clr_busy, bus.ovf_flag, bus.drop_cnt}),
        64'({1'b1, 1'b0, 1'b0, 16'h0}));
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Three camera writes land in order, then read back address 5.
    step(0, 0, 1, 5, 12'hABC, 0, 0);
    step(0, 0, 1, 6, 12'hABD, 0, 0);
    step(0, 0, 1, 7, 12'hABE, 0, 0);
    idle_steps(4);
    step(1, 5, 0, 0, '0, 0, 0);
    chk("read_addr5", 64'(bus.rd_data), 64'(12'hABC));
    step(1, 7, 0, 0, '0, 0, 0);

    // Reads own the port; the FIFO fills and the excess is dropped.
    for (int i = 0; i < 20; i++) step(1, 5, 1, 100 + i, 12'(i), 0, 0);
    chk("drop_cnt_4", 64'(bus.drop_cnt), 64'(16'd4));
    chk("ovf_set", 64'(bus.ovf_flag), 64'(1'b1));
    step(0, 0, 1, 200, 12'h777, 0, 0);
    chk("full_no_drop", 64'({bus.drop_cnt, bus.cam_ready}), 64'({16'd4, 1'b0}));
    step(1, 5, 1, 201, 12'h778, 0, 1);
    chk("ovf_clr_wins", 64'({bus.ovf_flag, bus.drop_cnt}), 64'(17'h0));
    idle_steps(20);
    for (int a = 100; a < 116; a++) step(1, a, 0, 0, '0, 0, 0);
    step(1, 115, 0, 0, '0, 0, 0);
    chk("fifo_last_kept", 64'(bus.rd_data), 64'(12'd15));
    step(1, 200, 0, 0, '0, 0, 0);
    chk("pushpop_kept", 64'(bus.rd_data), 64'(12'h777));

    // Uninterrupted clear: busy exactly NPIX cycles, restart request ignored.
    busy_cnt = 0;
    step(0, 0, 0, 0, '0, 1, 0);
    if (bus.clr_busy) busy_cnt++;
    for (int i = 0; i < int'(NPIX) + 4; i++) begin
      step(0, 0, 0, 0, '0, i == 100, 0);
      if (bus.clr_busy) busy_cnt++;
    end
    chk("clr_len", 64'(busy_cnt), 64'(NPIX));
    good = 0;
    for (int a = 0; a < int'(NPIX); a++) begin
      step(1, a, 0, 0, '0, 0, 0);
      if (bus.rd_data === CCOL) good++;
    end
    chk("clr_all_color", 64'(good), 64'(NPIX));

    // Clear with 50% reads and camera writes queued behind it.
    busy_cnt = 0;
    nwr = 0;
    step(0, 0, 0, 0, '0, 1, 0);
    if (bus.clr_busy) busy_cnt++;
    for (int i = 0; i < 2 * int'(NPIX) + 20 && bus.clr_busy; i++) begin
      int wa;
      logic [FB_DATA_W-1:0] wd;
      bit we;
      rd = (i % 2 == 0);
      we = (i % 50 == 1) && (nwr < 12);
      wa = int'($urandom_range(0, NPIX - 1));
      wd = 12'($urandom);
      if (we) begin
        nwr++;
        last_cam[wa] = int'(wd);
      end
      step(rd, int'($urandom_range(0, NPIX - 1)), we, wa, wd, 0, 0);
      if (bus.clr_busy) busy_cnt++;
    end
    chk("clr_len_2x", 64'(busy_cnt), 64'(2 * NPIX));
    idle_steps(20);
    for (int a = 0; a < int'(NPIX); a++) begin
      step(1, a, 0, 0, '0, 0, 0);
      if (last_cam.exists(a)) chk("cam_after_clear", 64'(bus.rd_data), 64'(last_cam[a]));
    end

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step(($urandom % 3) == 0, int'($urandom_range(0, NPIX - 1)), ($urandom % 2) == 0,
           int'($urandom_range(0, NPIX - 1)), 12'($urandom), ($urandom % 300) == 0,
           ($urandom % 40) == 0);
    end
    for (int i = 0; i < 3 * int'(NPIX) && (m_clearing || m_draining || q.size() > 0); i++)
      idle_steps(1);
    chk("random_settled", 64'({bus.clr_busy, bus.cam_ready}), 64'(2'b01));

    // Reset in the middle of a clear with a full FIFO and drops pending.
    step(0, 0, 0, 0, '0, 1, 0);
    for (int i = 0; i < 2000 && m_clr != 1000; i++)
      step(0, 0, i < 20, 300 + i, 12'hF0F, 0, 0);
    chk("busy_before_rst", 64'({bus.clr_busy, bus.ovf_flag, bus.cam_ready}), 64'(3'b110));
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async", 64'({bus.clr_busy, bus.cam_ready, bus.ovf_flag, bus.drop_cnt}),
        64'({1'b0, 1'b1, 1'b0, 16'h0}));
    @(posedge clk); #1;
    chk("rst_next_edge", 64'({bus.clr_busy, bus.cam_ready, bus.ovf_flag, bus.mem_en}),
        64'(4'b0100));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    idle_steps(3);
    step(0, 0, 1, 9, 12'h123, 0, 0);
    idle_steps(2);
    step(1, 9, 0, 0, '0, 0, 0);
    chk("after_rst_write", 64'(bus.rd_data), 64'(12'h123));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
